// File: rtl/traffic_pkg.sv
// Shared types and default constants for the traffic-light sensor front end.
package traffic_pkg;

    typedef enum logic [1:0] {S_LO, CHK_HI, S_HI, CHK_LO} deb_state_t;

    localparam int TICK_DIV_DEF   = 100_000_000;
    localparam int DEB_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-FF synchronizer, debounce FSM, one-cycle rise pulse
// and the sticky request flag that the light controller samples on tick.
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    output logic clean,
    output logic rise,
    output logic req
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    // Entry into a CHK state is itself the first stable sample, so the count
    // runs 0..DEB_CYCLES; this yields a clean edge DEB_CYCLES+3 edges after
    // the raw level is first sampled.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES);

    logic          s1, s2;
    deb_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          clean_nxt, rise_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= S_LO;
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            req   <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            clean <= clean_nxt;
            rise  <= rise_nxt;
            // A new arrival wins over a simultaneous tick.
            req   <= rise ? 1'b1 : (tick ? clean : req);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LO:    if (s2) state_nxt = CHK_HI;
            CHK_HI:  if (!s2) state_nxt = S_LO;
                     else if (cnt == CNT_LAST) state_nxt = S_HI;
            S_HI:    if (!s2) state_nxt = CHK_LO;
            CHK_LO:  if (s2) state_nxt = S_HI;
                     else if (cnt == CNT_LAST) state_nxt = S_LO;
            default: state_nxt = S_LO;
        endcase
    end

    always_comb begin
        cnt_nxt   = '0;
        clean_nxt = clean;
        rise_nxt  = 1'b0;
        case (state)
            CHK_HI: begin
                if (s2 && cnt == CNT_LAST) begin
                    clean_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                end else if (s2) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            CHK_LO: begin
                if (!s2 && cnt == CNT_LAST) begin
                    clean_nxt = 1'b0;
                end else if (!s2) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: cnt_nxt = '0;
        endcase
    end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Sensor front end for the traffic-light controller: two conditioned channels
// plus the free-running step-enable tick.
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic tick,
    output logic a_clean,
    output logic b_clean,
    output logic a_rise,
    output logic b_rise,
    output logic a_req,
    output logic b_req
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tcnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tcnt <= '0;
        end else if (tcnt == TLAST) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign tick = (tcnt == TLAST);

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk   (clk),
        .reset (reset),
        .raw   (a),
        .tick  (tick),
        .clean (a_clean),
        .rise  (a_rise),
        .req   (a_req)
    );

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk   (clk),
        .reset (reset),
        .raw   (b),
        .tick  (tick),
        .clean (b_clean),
        .rise  (b_rise),
        .req   (b_req)
    );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner with TICK_DIV=16, DEB_CYCLES=4.
module tb_traffic_sensor_conditioner;

    localparam int TD  = 16;
    localparam int DC  = 4;
    localparam int LAT = DC + 3;

    typedef struct {
        logic       a;
        logic       b;
        logic [5:0] exp;   // {a_clean, a_rise, a_req, b_clean, b_rise, b_req}
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic tick, a_clean, b_clean, a_rise, b_rise, a_req, b_req;

    int checks = 0;
    int errors = 0;
    int cyc = 0;   // edges since reset release

    vec_t vecs[20];

    traffic_sensor_conditioner #(.TICK_DIV(TD), .DEB_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .tick    (tick),
        .a_clean (a_clean),
        .b_clean (b_clean),
        .a_rise  (a_rise),
        .b_rise  (b_rise),
        .a_req   (a_req),
        .b_req   (b_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (reset) cyc++;
        else cyc = 0;
        chk("tick", tick, reset && ((cyc % TD) == TD - 1));
    endtask

    task automatic chk_all(input logic [5:0] e, input string tag);
        chk({tag, ".a_clean"}, a_clean, e[5]);
        chk({tag, ".a_rise"},  a_rise,  e[4]);
        chk({tag, ".a_req"},   a_req,   e[3]);
        chk({tag, ".b_clean"}, b_clean, e[2]);
        chk({tag, ".b_rise"},  b_rise,  e[1]);
        chk({tag, ".b_req"},   b_req,   e[0]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        a = 1'b0;
        b = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        // Table: a rises at edge 1, b rises at edge 11; row k lands on edge k+1.
        for (int k = 0; k < 20; k++) begin
            int c;
            c = k + 1;
            vecs[k].a = 1'b1;
            vecs[k].b = (c >= 11);
            vecs[k].exp = {c >= 1 + LAT, c == 1 + LAT, c >= 2 + LAT,
                           c >= 11 + LAT, c == 11 + LAT, c >= 12 + LAT};
        end

        // Reset held with both sensors high, then tick cadence.
        reset = 1'b0;
        a = 1'b1;
        b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all(6'b000000, "reset_hold");
        end
        a = 1'b0;
        b = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 2 * TD + 1; i++) step();

        // Table-driven rise on a then b, car still present across a tick.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            a = vecs[k].a;
            b = vecs[k].b;
            step();
            chk_all(vecs[k].exp, "table");
        end

        // Bounce: 3 samples high, 3 low, five times, never accepted.
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 6; i++) begin
                a = (i < 3);
                step();
                chk_all(6'b000000, "bounce");
            end
        end
        a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_all(6'b000000, "bounce_settle");
        end

        // Short car between ticks: req held until the tick after clean falls.
        do_reset();
        for (int n = 1; n <= 33; n++) begin
            a = (n >= 11 && n <= 20);
            step();
            chk("short.a_clean", a_clean, n >= 18 && n <= 27);
            chk("short.a_rise",  a_rise,  n == 18);
            chk("short.a_req",   a_req,   n >= 19 && n <= 31);
        end

        // Rise on both channels in the tick cycle.
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            a = (n >= 8);
            b = (n >= 8);
            step();
            if (n == 15) chk_all(6'b110110, "rise_at_tick");
            if (n == 16) chk_all(6'b101101, "after_tick");
        end

        // Reset while a is mid-qualification, then full latency again.
        do_reset();
        a = 1'b1;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b0;
        step();
        chk_all(6'b000000, "mid_reset");
        reset = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            step();
            chk("requal.a_clean", a_clean, n >= 8);
            chk("requal.a_rise",  a_rise,  n == 8);
            chk("requal.a_req",   a_req,   n >= 9);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
